// File: rtl/fifo_read_transmitter.sv
// Read-domain FIFO drain: pops one word at a time and shifts it out MSB-first,
// followed by an acknowledge slot; a NACK latches nack_error and halts draining.
module fifo_read_transmitter #(
    parameter int data_size = 8,
    parameter int clk_div   = 4
) (
    input  logic                 read_clk,
    input  logic                 read_reset,
    input  logic [data_size-1:0] read_data,
    input  logic                 read_empty,
    output logic                 read_increment,
    input  logic                 enable,
    input  logic                 ack_in,
    input  logic                 clear_error,
    output logic                 serial_out,
    output logic                 bit_valid,
    output logic                 byte_done,
    output logic                 nack_error,
    output logic                 busy
);

    localparam int bit_w = $clog2(data_size + 1);
    localparam int div_w = $clog2(clk_div);
    localparam logic [bit_w-1:0] bit_last = bit_w'(data_size - 1);
    localparam logic [div_w-1:0] div_last = div_w'(clk_div - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [data_size-1:0] shift_reg;
    logic [bit_w-1:0]     bit_cnt;
    logic [div_w-1:0]     div_cnt;
    logic                 div_tick;
    logic                 nack_set;

    always_comb begin
        state_next     = state;
        read_increment = 1'b0;
        serial_out     = 1'b1;
        bit_valid      = 1'b0;
        byte_done      = 1'b0;
        busy           = 1'b0;
        nack_set       = 1'b0;
        div_tick       = (div_cnt == div_last);
        case (state)
            IDLE: begin
                read_increment = enable & ~read_empty & ~nack_error & ~read_reset;
                if (read_increment) state_next = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                serial_out = shift_reg[data_size-1];
                bit_valid  = div_tick;
                if (div_tick && bit_cnt == bit_last) state_next = ACK;
            end
            ACK: begin
                busy = 1'b1;
                if (div_tick) begin
                    state_next = IDLE;
                    byte_done  = ~ack_in;
                    nack_set   = ack_in;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            nack_error <= 1'b0;
        end else begin
            state <= state_next;
            // A NACK sampled in the same cycle as clear_error keeps the flag set.
            if (nack_set)
                nack_error <= 1'b1;
            else if (clear_error)
                nack_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_increment) begin
                        shift_reg <= read_data;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (div_tick) begin
                        div_cnt   <= '0;
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= (bit_cnt == bit_last) ? '0 : bit_cnt + bit_w'(1);
                    end else begin
                        div_cnt <= div_cnt + div_w'(1);
                    end
                end
                ACK: begin
                    div_cnt <= div_tick ? '0 : div_cnt + div_w'(1);
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_transmitter.sv
// Directed bench for fifo_read_transmitter (data_size=8, clk_div=4) with a queue-backed FIFO model.
module tb_fifo_read_transmitter;

    logic       read_clk = 1'b0;
    logic       read_reset;
    logic [7:0] read_data;
    logic       read_empty;
    logic       read_increment;
    logic       enable;
    logic       ack_in;
    logic       clear_error;
    logic       serial_out;
    logic       bit_valid;
    logic       byte_done;
    logic       nack_error;
    logic       busy;

    logic [7:0] fifo_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 read_clk = ~read_clk;

    fifo_read_transmitter #(
        .data_size(8),
        .clk_div  (4)
    ) dut (
        .read_clk      (read_clk),
        .read_reset    (read_reset),
        .read_data     (read_data),
        .read_empty    (read_empty),
        .read_increment(read_increment),
        .enable        (enable),
        .ack_in        (ack_in),
        .clear_error   (clear_error),
        .serial_out    (serial_out),
        .bit_valid     (bit_valid),
        .byte_done     (byte_done),
        .nack_error    (nack_error),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic refresh();
        read_empty = (fifo_q.size() == 0);
        read_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    // Advance one cycle, popping the model FIFO when the DUT strobed read_increment.
    task automatic tick();
        logic pop;
        pop = read_increment;
        @(posedge read_clk);
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        refresh();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_inc"},  {31'd0, read_increment}, 32'd0);
        check({tag, "_ser"},  {31'd0, serial_out},     32'd1);
        check({tag, "_busy"}, {31'd0, busy},           32'd0);
        check({tag, "_bv"},   {31'd0, bit_valid},      32'd0);
    endtask

    // Current cycle must be the pop cycle (cycle 0); returns at cycle 37.
    task automatic watch_frame(input logic [7:0] b, input logic nack, input logic clr, input int en_off_at);
        for (int c = 0; c <= 36; c++) begin
            if (c == en_off_at) enable = 1'b0;
            ack_in      = (c >= 33 && c <= 35) ? ~nack : (c == 36 ? nack : 1'b0);
            clear_error = (c == 36) ? clr : 1'b0;
            #1;
            check("inc",  {31'd0, read_increment}, {31'd0, c == 0});
            check("busy", {31'd0, busy},           {31'd0, c >= 1});
            check("ser",  {31'd0, serial_out},
                  {31'd0, (c >= 1 && c <= 32) ? b[7 - (c - 1) / 4] : 1'b1});
            check("bv",   {31'd0, bit_valid},      {31'd0, c >= 4 && c <= 32 && c % 4 == 0});
            check("done", {31'd0, byte_done},      {31'd0, c == 36 && !nack});
            check("nack_in_frame", {31'd0, nack_error}, 32'd0);
            tick();
        end
        ack_in      = 1'b0;
        clear_error = 1'b0;
    endtask

    initial begin
        read_reset  = 1'b1;
        enable      = 1'b0;
        ack_in      = 1'b0;
        clear_error = 1'b0;
        refresh();
        tick();
        tick();
        read_reset = 1'b0;
        #1;
        check_idle("reset");
        check("reset_done", {31'd0, byte_done},  32'd0);
        check("reset_nack", {31'd0, nack_error}, 32'd0);

        // Empty FIFO: nothing happens
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            check_idle("empty");
            tick();
        end

        // Single byte 0xA5
        fifo_q.push_back(8'hA5);
        refresh();
        watch_frame(8'hA5, 1'b0, 1'b0, -1);
        #1;
        check_idle("after_a5");

        // Back-to-back bytes: second pop at cycle 37
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        refresh();
        watch_frame(8'h01, 1'b0, 1'b0, -1);
        watch_frame(8'hFF, 1'b0, 1'b0, -1);
        #1;
        check_idle("after_ff");

        // NACK with simultaneous clear_error: NACK wins, draining halts
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h55);
        refresh();
        watch_frame(8'h3C, 1'b1, 1'b1, -1);
        for (int c = 37; c <= 50; c++) begin
            clear_error = (c == 50);
            #1;
            check("nack_set", {31'd0, nack_error}, 32'd1);
            check_idle("nack_hold");
            check("nack_nodone", {31'd0, byte_done}, 32'd0);
            tick();
        end
        clear_error = 1'b0;
        #1;
        check("nack_cleared", {31'd0, nack_error}, 32'd0);
        watch_frame(8'h55, 1'b0, 1'b0, -1);

        // Reset in the middle of a byte
        fifo_q.push_back(8'h96);
        refresh();
        for (int c = 0; c <= 14; c++) begin
            read_reset = (c == 14);
            #1;
            check("rst_inc", {31'd0, read_increment}, {31'd0, c == 0});
            if (c >= 1)
                check("rst_ser", {31'd0, serial_out}, {31'd0, fifo_q.size() == 0 ? 1'b1 : 1'b0} & 32'd0 | {31'd0, 8'h96 >> (7 - (c - 1) / 4) & 8'h01});
            tick();
        end
        fifo_q.push_back(8'h42);
        refresh();
        #1;
        check_idle("rst_mid");
        check("rst_nack", {31'd0, nack_error}, 32'd0);
        check("rst_done", {31'd0, byte_done},  32'd0);
        tick();
        read_reset = 1'b0;
        watch_frame(8'h42, 1'b0, 1'b0, -1);

        // enable drops mid-byte: byte completes, no further pop
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        refresh();
        watch_frame(8'h11, 1'b0, 1'b0, 10);
        for (int c = 37; c <= 50; c++) begin
            #1;
            check_idle("en_off");
            tick();
        end
        check("en_off_depth", fifo_q.size(), 32'd1);
        enable = 1'b1;
        watch_frame(8'h22, 1'b0, 1'b0, -1);
        check("final_depth", fifo_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
